// File: rtl/alog_pkg.sv
// Shared types for the alog frame transmitter: sample width, frame FSM states, triplet payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alog_pkg;

    // Sample width of every channel in a triplet.
    localparam int DW = 14;

    // Frame sequencer states: waiting for data, head_flag window, low gap.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_GAP  = 2'd2
    } frame_state_t;

    // One acquisition triplet. The reference field cannot be called "ref"
    // because that is a reserved word, hence ref_smp.
    typedef struct packed {
        logic [DW-1:0] ch2;
        logic [DW-1:0] ch3;
        logic [DW-1:0] ref_smp;
    } triplet_t;

endpackage

// File: rtl/alog_triplet_fifo.sv
// Synchronous FIFO of triplets with registered full/empty and simultaneous push/pop.
// Latency: a pushed entry is visible at pop_dat (empty low) the cycle after the write edge.
// Backpressure: push is ignored while full; pop is ignored while empty.
module alog_triplet_fifo
    import alog_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  triplet_t push_dat,
    input  logic     pop,
    output triplet_t pop_dat,
    output logic     full,
    output logic     empty
);

    // DEPTH is a power of two >= 2, so the pointers wrap naturally.
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    triplet_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_nxt;
    logic            do_push;
    logic            do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; a simultaneous pair leaves it unchanged.
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers, count and registered full/empty flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_FULL);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/alog_frame_tx.sv
// Frame transmitter: buffers triplets and issues one head_flag window (HOLD high, GAP low) per triplet.
// Latency: push to head_flag rise is 2 cycles from an empty FIFO; frame period >= HOLD+GAP+1 cycles.
// Backpressure: in_ready = FIFO not full; a valid offered while not ready is dropped and sets sticky overrun.
module alog_frame_tx
    import alog_pkg::*;
#(
    parameter int HOLD_CYCLES = 20,
    parameter int GAP_CYCLES  = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_ch2,
    input  logic [DW-1:0] in_ch3,
    input  logic [DW-1:0] in_ref,
    output logic          head_flag,
    output logic [DW-1:0] buffer_2,
    output logic [DW-1:0] buffer_3,
    output logic [DW-1:0] reff,
    output logic [15:0]   frame_cnt,
    output logic          overrun
);

    // One down-counter serves both the hold and the gap phase.
    localparam int            CNT_MAX   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int            CW        = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    frame_state_t  state_q;
    frame_state_t  state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          frame_done;
    triplet_t      push_dat;
    triplet_t      pop_dat;

    // in_ready comes straight from the FIFO's registered full flag, so a pop
    // only re-opens the input on the cycle after it happens.
    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready;
    assign push_dat = '{ch2: in_ch2, ch3: in_ch3, ref_smp: in_ref};

    alog_triplet_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Frame state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave IDLE on data, end HEAD/GAP when the counter reaches zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty)   state_d = ST_HEAD;
            ST_HEAD: if (cnt_q == '0)   state_d = ST_GAP;
            ST_GAP:  if (cnt_q == '0)   state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Per-state control: pop strobe, counter next value, end-of-frame strobe.
    always_comb begin
        pop        = 1'b0;
        cnt_d      = cnt_q;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    cnt_d = HOLD_LOAD;
                end
            end
            ST_HEAD: begin
                if (cnt_q == '0) begin
                    cnt_d      = GAP_LOAD;
                    frame_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Phase counter and head_flag; head_flag is registered from the next state
    // so it rises on the same edge that pops the payload.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            head_flag <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            head_flag <= (state_d == ST_HEAD);
        end
    end

    // Payload registers load only on a pop and hold through GAP and IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buffer_2 <= '0;
            buffer_3 <= '0;
            reff     <= '0;
        end else if (pop) begin
            buffer_2 <= pop_dat.ch2;
            buffer_3 <= pop_dat.ch3;
            reff     <= pop_dat.ref_smp;
        end
    end

    // Frame counter (wraps) and sticky overrun flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alog_frame_tx.sv
// Directed bench for alog_frame_tx: reset, single frame, back-to-back, full/overrun, mid-frame reset.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_alog_frame_tx;
    import alog_pkg::*;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_ch2    = '0;
    logic [DW-1:0] in_ch3    = '0;
    logic [DW-1:0] in_ref    = '0;
    logic          in_ready;
    logic          head_flag;
    logic [DW-1:0] buffer_2;
    logic [DW-1:0] buffer_3;
    logic [DW-1:0] reff;
    logic [15:0]   frame_cnt;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    triplet_t vec [0:5];

    alog_frame_tx dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch2    (in_ch2),
        .in_ch3    (in_ch3),
        .in_ref    (in_ref),
        .head_flag (head_flag),
        .buffer_2  (buffer_2),
        .buffer_3  (buffer_3),
        .reff      (reff),
        .frame_cnt (frame_cnt),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Record each head_flag rise with the cycle number and the payload shown.
    logic     hf_prev = 1'b0;
    int       rise_cyc [$];
    triplet_t rise_dat [$];
    always @(negedge clk) begin
        if (head_flag === 1'b1 && hf_prev !== 1'b1) begin
            rise_cyc.push_back(cyc);
            rise_dat.push_back({buffer_2, buffer_3, reff});
        end
        hf_prev = head_flag;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input triplet_t t);
        in_valid = 1'b1;
        in_ch2   = t.ch2;
        in_ch3   = t.ch3;
        in_ref   = t.ref_smp;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rstn     = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        rise_cyc.delete();
        rise_dat.delete();
    endtask

    task automatic test_reset();
        int hi;
        in_valid = 1'b0;
        rstn     = 1'b0;
        repeat (3) tick();
        checks++; if (head_flag !== 1'b0) begin errors++; $display("FAIL reset_head_flag got %b exp 0", head_flag); end
        checks++; if ({buffer_2, buffer_3, reff} !== '0) begin errors++; $display("FAIL reset_payload got %h %h %h exp 0 0 0", buffer_2, buffer_3, reff); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rstn = 1'b1;
        hi = 0;
        repeat (50) begin
            tick();
            if (head_flag !== 1'b0) hi++;
        end
        checks++; if (hi != 0) begin errors++; $display("FAIL reset_idle_quiet got %0d high cycles exp 0", hi); end
    endtask

    task automatic test_single();
        int n;
        int guard;
        int lo_bad;
        do_reset();
        drive(vec[0]);
        tick();
        in_valid = 1'b0;
        checks++; if (head_flag !== 1'b0) begin errors++; $display("FAIL single_no_rise_at_write got %b exp 0", head_flag); end
        tick();
        checks++; if (head_flag !== 1'b1) begin errors++; $display("FAIL single_rise_2cyc got %b exp 1", head_flag); end
        checks++; if ({buffer_2, buffer_3, reff} !== {14'h0123, 14'h0456, 14'h1FFF}) begin
            errors++; $display("FAIL single_payload got %h %h %h exp 0123 0456 1fff", buffer_2, buffer_3, reff);
        end
        n = 1;
        guard = 0;
        while (head_flag === 1'b1 && guard < 100) begin
            tick();
            guard++;
            if (head_flag === 1'b1) n++;
        end
        checks++; if (n != 20) begin errors++; $display("FAIL single_hold_len got %0d exp 20", n); end
        lo_bad = 0;
        repeat (3) begin
            if (head_flag !== 1'b0) lo_bad++;
            tick();
        end
        checks++; if (lo_bad != 0) begin errors++; $display("FAIL single_gap_low got %0d high cycles exp 0", lo_bad); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frame_cnt got %0d exp 1", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int push_cyc;
        do_reset();
        push_cyc = cyc;
        for (int i = 0; i < 4; i++) begin
            drive(vec[i]);
            tick();
        end
        in_valid = 1'b0;
        repeat (110) tick();
        checks++; if (rise_cyc.size() != 4) begin errors++; $display("FAIL b2b_frames got %0d exp 4", rise_cyc.size()); end
        if (rise_cyc.size() == 4) begin
            checks++; if (rise_cyc[0] - push_cyc != 2) begin errors++; $display("FAIL b2b_first_latency got %0d exp 2", rise_cyc[0] - push_cyc); end
            for (int i = 1; i < 4; i++) begin
                checks++; if (rise_cyc[i] - rise_cyc[i-1] != 23) begin
                    errors++; $display("FAIL b2b_period_%0d got %0d exp 23", i, rise_cyc[i] - rise_cyc[i-1]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++; if (rise_dat[i] !== vec[i]) begin
                    errors++; $display("FAIL b2b_payload_%0d got %h exp %h", i, rise_dat[i], vec[i]);
                end
            end
        end
        checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL b2b_frame_cnt got %0d exp 4", frame_cnt); end
    endtask

    // Five pushes with no gaps; the second lands on the edge that pops the
    // first, so the FIFO only fills on the fifth push.
    task automatic test_simul_push_pop();
        logic [4:0] rdy_exp;
        do_reset();
        rdy_exp = 5'b01111;
        for (int i = 0; i < 5; i++) begin
            drive(vec[i]);
            tick();
            checks++; if (in_ready !== rdy_exp[i]) begin
                errors++; $display("FAIL simul_in_ready_after_push%0d got %b exp %b", i + 1, in_ready, rdy_exp[i]);
            end
            if (i == 1) begin
                checks++; if (head_flag !== 1'b1 || buffer_2 !== vec[0].ch2) begin
                    errors++; $display("FAIL simul_pop_with_push got hf=%b ch2=%h exp hf=1 ch2=%h", head_flag, buffer_2, vec[0].ch2);
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL simul_no_overrun got %b exp 0", overrun); end
    endtask

    // Continues from the full FIFO left by test_simul_push_pop.
    task automatic test_overrun();
        drive(vec[5]);
        tick();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
        repeat (2) tick();
        in_valid = 1'b0;
        repeat (16) tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovr_ready_before_pop got %b exp 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ovr_ready_after_pop got %b exp 1", in_ready); end
        checks++; if (head_flag !== 1'b1 || buffer_2 !== vec[1].ch2) begin
            errors++; $display("FAIL ovr_second_frame got hf=%b ch2=%h exp hf=1 ch2=%h", head_flag, buffer_2, vec[1].ch2);
        end
        repeat (100) tick();
        checks++; if (rise_cyc.size() != 5) begin errors++; $display("FAIL ovr_frames got %0d exp 5", rise_cyc.size()); end
        if (rise_cyc.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (rise_dat[i] !== vec[i]) begin
                    errors++; $display("FAIL ovr_payload_%0d got %h exp %h", i, rise_dat[i], vec[i]);
                end
            end
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
        checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL ovr_frame_cnt got %0d exp 5", frame_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int hi;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(vec[i]);
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        checks++; if (head_flag !== 1'b1) begin errors++; $display("FAIL mid_in_head got %b exp 1", head_flag); end
        rstn = 1'b0;
        #1;
        checks++; if (head_flag !== 1'b0) begin errors++; $display("FAIL mid_async_head got %b exp 0", head_flag); end
        checks++; if ({buffer_2, buffer_3, reff} !== '0) begin errors++; $display("FAIL mid_async_payload got %h %h %h exp 0 0 0", buffer_2, buffer_3, reff); end
        checks++; if (in_ready !== 1'b1 || frame_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_async_status got rdy=%b cnt=%0d exp rdy=1 cnt=0", in_ready, frame_cnt);
        end
        repeat (2) tick();
        rstn = 1'b1;
        hi = 0;
        repeat (60) begin
            tick();
            if (head_flag !== 1'b0) hi++;
        end
        checks++; if (hi != 0) begin errors++; $display("FAIL mid_fifo_flushed got %0d high cycles exp 0", hi); end
        drive(vec[5]);
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (head_flag !== 1'b1 || {buffer_2, buffer_3, reff} !== vec[5]) begin
            errors++; $display("FAIL mid_new_frame got hf=%b %h exp hf=1 %h", head_flag, {buffer_2, buffer_3, reff}, vec[5]);
        end
    endtask

    initial begin
        vec[0] = '{ch2: 14'h0123, ch3: 14'h0456, ref_smp: 14'h1FFF};
        vec[1] = '{ch2: 14'h3FFF, ch3: 14'h0001, ref_smp: 14'h2AAA};
        vec[2] = '{ch2: 14'h1555, ch3: 14'h3C3C, ref_smp: 14'h0000};
        vec[3] = '{ch2: 14'h0F0F, ch3: 14'h2222, ref_smp: 14'h3333};
        vec[4] = '{ch2: 14'h1234, ch3: 14'h0BCD, ref_smp: 14'h0777};
        vec[5] = '{ch2: 14'h2DEA, ch3: 14'h1BEE, ref_smp: 14'h0ACE};

        test_reset();
        test_single();
        test_back_to_back();
        test_simul_push_pop();
        test_overrun();
        test_reset_mid_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
